trsq8_fetch: RTL



---
 rtl/trsq8_pkg.sv | 28 ++
 rtl/trsq8_pc.sv | 36 +++
 rtl/trsq8_fetch.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/trsq8_pkg.sv
// ---------------------------------------------------------------------------
// trsq8_pkg
// Shared types and constants for the TRSQ8 instruction-fetch slice.
//   INST_W / PADDR_W : program ROM word width and address width
//   inst_t / paddr_t : typed aliases for ROM words and ROM addresses
//   fetch_state_t    : fetch sequencer state (RUN, STALL, HALT)
//   pc_next_seq      : sequential PC successor, wraps modulo 2^PADDR_W
// ---------------------------------------------------------------------------
package trsq8_pkg;

  localparam int INST_W  = 15;
  localparam int PADDR_W = 13;

  typedef logic [INST_W-1:0]  inst_t;
  typedef logic [PADDR_W-1:0] paddr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // 13-bit addition drops the carry, so 13'h1FFF + 1 wraps to 13'h0000.
  function automatic paddr_t pc_next_seq(input paddr_t pc);
    return pc + paddr_t'(1);
  endfunction

endpackage

// File: rtl/trsq8_pc.sv
// ---------------------------------------------------------------------------
// trsq8_pc
// Program counter register for the TRSQ8 fetch sequencer.
// Load has priority over increment; with neither asserted the PC holds.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset (PC <= RESET_PC)
//   load       in   load load_addr (jump redirect)
//   load_addr  in   13-bit redirect target
//   inc        in   advance to the next sequential address (wraps)
//   pc         out  current program counter
// ---------------------------------------------------------------------------
module trsq8_pc
  import trsq8_pkg::*;
#(
  parameter logic [12:0] RESET_PC = 13'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [12:0] load_addr,
  input  logic        inc,
  output logic [12:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc_next_seq(pc);
    end
  end

endmodule

// File: rtl/trsq8_fetch.sv
// ---------------------------------------------------------------------------
// trsq8_fetch
// Instruction-fetch sequencer for the TRSQ8 core. Drives the address of the
// combinational program ROM, registers the returned word into a one-entry
// slot handed to the decoder with valid/ready, handles jump redirects and
// halt, and shares the ROM with a debug read port.
//
// Build option: define TRSQ8_FETCH_DBG_EN to include the debug read port,
// its starvation counter and the arbitration. Without it the DBG_* inputs
// are ignored, DBG_ACK_op/DBG_DATA_op are 0 and the ROM always sees the PC.
//
// Ports:
//   CLK_ip         in   system clock
//   RST_ip         in   asynchronous, active-high reset
//   PROM_ADDR_op   out  ROM address (PC, or DBG_ADDR_ip on a debug grant)
//   PROM_DATA_ip   in   ROM word for PROM_ADDR_op, same cycle
//   INST_op        out  registered instruction
//   INST_PC_op     out  address INST_op was fetched from
//   INST_VALID_op  out  slot holds a valid instruction
//   INST_READY_ip  in   decoder consumes the slot when VALID && READY
//   JUMP_ip        in   single-cycle redirect pulse
//   JUMP_ADDR_ip   in   redirect target
//   HALT_ip        in   level; no fetches issued while high
//   DBG_REQ_ip     in   debug read request, held until ack
//   DBG_ADDR_ip    in   debug read address
//   DBG_DATA_op    out  debug read data, registered
//   DBG_ACK_op     out  one-cycle pulse, DBG_DATA_op valid in that cycle
// ---------------------------------------------------------------------------
module trsq8_fetch
  import trsq8_pkg::*;
#(
  parameter logic [12:0] RESET_PC     = 13'd0,
  parameter int          DBG_MAX_WAIT = 4
) (
  input  logic        CLK_ip,
  input  logic        RST_ip,
  output logic [12:0] PROM_ADDR_op,
  input  logic [14:0] PROM_DATA_ip,
  output logic [14:0] INST_op,
  output logic [12:0] INST_PC_op,
  output logic        INST_VALID_op,
  input  logic        INST_READY_ip,
  input  logic        JUMP_ip,
  input  logic [12:0] JUMP_ADDR_ip,
  input  logic        HALT_ip,
  input  logic        DBG_REQ_ip,
  input  logic [12:0] DBG_ADDR_ip,
  output logic [14:0] DBG_DATA_op,
  output logic        DBG_ACK_op
);

  paddr_t       pc;
  inst_t        inst_reg;
  paddr_t       inst_pc_reg;
  logic         inst_valid_reg;
  fetch_state_t fetch_state;
  logic         consume;
  logic         fetch_would;
  logic         dbg_grant;
  logic         fetch_go;

  // The state is a function of the live HALT_ip / READY inputs and the slot
  // flag, so that a falling HALT_ip or a returning READY issues a fetch in
  // the very same cycle (no extra turnaround edge).
  always_comb begin
    fetch_state = RUN;
    if (HALT_ip) begin
      fetch_state = HALT;
    end else if (inst_valid_reg && !INST_READY_ip) begin
      fetch_state = STALL;
    end
  end

  assign consume     = inst_valid_reg && INST_READY_ip;
  assign fetch_would = (fetch_state == RUN);

`ifdef TRSQ8_FETCH_DBG_EN
  // Counter width is at least 1 bit so DBG_MAX_WAIT = 0 still elaborates.
  localparam int WCW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(DBG_MAX_WAIT);

  logic [WCW-1:0] wait_cnt_reg;
  inst_t          dbg_data_reg;
  logic           dbg_ack_reg;

  // Jump always wins. Debug takes the ROM for free when no fetch would
  // issue, and forcibly once it has been starved for DBG_MAX_WAIT cycles.
  assign dbg_grant = DBG_REQ_ip && !JUMP_ip &&
                     (!fetch_would || (wait_cnt_reg >= WAIT_LIM));

  always_ff @(posedge CLK_ip or posedge RST_ip) begin
    if (RST_ip) begin
      wait_cnt_reg <= '0;
      dbg_data_reg <= '0;
      dbg_ack_reg  <= 1'b0;
    end else begin
      dbg_ack_reg <= dbg_grant;
      if (dbg_grant) begin
        dbg_data_reg <= PROM_DATA_ip;
        wait_cnt_reg <= '0;
      end else if (!DBG_REQ_ip) begin
        wait_cnt_reg <= '0;
      end else if (wait_cnt_reg < WAIT_LIM) begin
        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
      end
    end
  end

  assign PROM_ADDR_op = dbg_grant ? DBG_ADDR_ip : pc;
  assign DBG_DATA_op  = dbg_data_reg;
  assign DBG_ACK_op   = dbg_ack_reg;
`else
  wire unused_dbg = ^{DBG_REQ_ip, DBG_ADDR_ip};

  assign dbg_grant    = 1'b0;
  assign PROM_ADDR_op = pc;
  assign DBG_DATA_op  = '0;
  assign DBG_ACK_op   = 1'b0;
`endif

  assign fetch_go = fetch_would && !JUMP_ip && !dbg_grant;

  trsq8_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (CLK_ip),
    .rst       (RST_ip),
    .load      (JUMP_ip),
    .load_addr (JUMP_ADDR_ip),
    .inc       (fetch_go),
    .pc        (pc)
  );

  // Instruction slot: a jump flushes, a fetch refills (this also covers a
  // consume in the same cycle), a consume with no refill empties it.
  always_ff @(posedge CLK_ip or posedge RST_ip) begin
    if (RST_ip) begin
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
    end else if (JUMP_ip) begin
      inst_valid_reg <= 1'b0;
    end else if (fetch_go) begin
      inst_reg       <= PROM_DATA_ip;
      inst_pc_reg    <= pc;
      inst_valid_reg <= 1'b1;
    end else if (consume) begin
      inst_valid_reg <= 1'b0;
    end
  end

  assign INST_op       = inst_reg;
  assign INST_PC_op    = inst_pc_reg;
  assign INST_VALID_op = inst_valid_reg;

endmodule
